// File: rtl/branch_predictor.sv
// Direct-mapped branch history/target table for beq/bne in IF, trained from
// ID-stage equality results, with a one-cycle registered mispredict flush.
module branch_predictor #(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_eq,
  input  logic        upd_is_beq,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic [15:0] mispredict_cnt
);

  localparam int TAG_W = 30 - IDX_W;
  localparam int DEPTH = 2 ** IDX_W;

  logic [DEPTH-1:0] r_valid;
  logic [TAG_W-1:0] r_tag    [DEPTH];
  logic [1:0]       r_ctr    [DEPTH];
  logic [31:0]      r_target [DEPTH];

  logic             r_flush;
  logic [31:0]      r_flush_pc;
  logic [15:0]      r_mp_cnt;

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;
  logic             w_lk_taken;
  logic [31:0]      w_lk_target;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic             w_taken;
  logic             w_mp;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  // Lookup reads only registered table state, so same-index updates show next cycle
  always_comb begin
    w_lk_idx   = if_pc[IDX_W+1:2];
    w_lk_tag   = if_pc[31:IDX_W+2];
    w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    w_lk_taken = w_lk_hit && r_ctr[w_lk_idx][1];
    if (w_lk_taken) begin
      w_lk_target = r_target[w_lk_idx];
    end else begin
      w_lk_target = if_pc + 32'd4;
    end
  end

  // Resolved-branch decode: actual direction and mispredict detection
  always_comb begin
    w_up_idx = upd_pc[IDX_W+1:2];
    w_up_tag = upd_pc[31:IDX_W+2];
    w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    if (upd_is_beq) begin
      w_taken = upd_eq;
    end else begin
      w_taken = ~upd_eq;
    end
    w_mp = upd_valid && (w_taken != upd_pred_taken);
  end

  assign pred_hit       = w_lk_hit;
  assign pred_taken     = w_lk_taken;
  assign pred_target    = w_lk_target;
  assign flush          = r_flush;
  assign flush_pc       = r_flush_pc;
  assign mispredict_cnt = r_mp_cnt;

  // Table training; a not-taken miss never allocates, so aliases evict only on taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i]    <= '0;
        r_ctr[i]    <= 2'b01;
        r_target[i] <= 32'd0;
      end
    end else if (upd_valid) begin
      if (w_up_hit) begin
        if (w_taken) begin
          r_ctr[w_up_idx]    <= ctr_inc(r_ctr[w_up_idx]);
          r_target[w_up_idx] <= upd_target;
        end else begin
          r_ctr[w_up_idx] <= ctr_dec(r_ctr[w_up_idx]);
        end
      end else if (w_taken) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_ctr[w_up_idx]    <= 2'b10;
        r_target[w_up_idx] <= upd_target;
      end
    end
  end

  // Mispredict flush pulse, corrected PC and saturating event counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush    <= 1'b0;
      r_flush_pc <= 32'd0;
      r_mp_cnt   <= 16'd0;
    end else begin
      r_flush <= w_mp;
      if (w_mp) begin
        r_flush_pc <= w_taken ? upd_target : upd_pc + 32'd4;
        if (r_mp_cnt != 16'hFFFF) begin
          r_mp_cnt <= r_mp_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized self-checking bench for branch_predictor against a table-level
// reference model (integer counters, PC-derived index/tag).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] if_pc = 32'd0;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'd0;
  logic        upd_eq = 1'b0, upd_is_beq = 1'b0, upd_pred_taken = 1'b0;
  logic [31:0] upd_target = 32'd0;
  logic        flush;
  logic [31:0] flush_pc;
  logic [15:0] mispredict_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          m_valid [16];
  int unsigned m_tag   [16];
  int          m_ctr   [16];
  logic [31:0] m_tgt   [16];
  logic        m_flush;
  logic [31:0] m_flush_pc;
  int          m_cnt;

  branch_predictor #(.IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_eq(upd_eq),
    .upd_is_beq(upd_is_beq), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken),
    .flush(flush), .flush_pc(flush_pc), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_ctr[i]   = 1;
      m_tgt[i]   = 32'd0;
    end
    m_flush    = 1'b0;
    m_flush_pc = 32'd0;
    m_cnt      = 0;
  endtask

  function automatic bit m_hit(input logic [31:0] pc);
    int idx = (pc >> 2) % 16;
    return m_valid[idx] && (m_tag[idx] == (pc >> 6));
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    int idx = (pc >> 2) % 16;
    return m_hit(pc) && (m_ctr[idx] >= 2);
  endfunction

  // One cycle: check registered outputs, drive, check lookup, advance the model
  task automatic step(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                      input logic eq, input logic beq, input logic [31:0] tgt,
                      input logic pt);
    int  lidx, uidx;
    bit  tk, hit, ltaken;
    @(negedge clk);
    check_eq("flush", flush, m_flush);
    check_eq("flush_pc", flush_pc, m_flush_pc);
    check_eq("mp_cnt", mispredict_cnt, m_cnt);
    if_pc = lpc; upd_valid = uv; upd_pc = upc; upd_eq = eq;
    upd_is_beq = beq; upd_target = tgt; upd_pred_taken = pt;
    #1;
    lidx   = (lpc >> 2) % 16;
    ltaken = m_pred(lpc);
    check_eq("pred_hit", pred_hit, m_hit(lpc));
    check_eq("pred_taken", pred_taken, ltaken);
    check_eq("pred_target", pred_target, ltaken ? m_tgt[lidx] : lpc + 32'd4);
    tk = beq ? eq : !eq;
    if (uv) begin
      uidx = (upc >> 2) % 16;
      hit  = m_hit(upc);
      if (hit && tk) begin
        m_ctr[uidx] = (m_ctr[uidx] < 3) ? m_ctr[uidx] + 1 : 3;
        m_tgt[uidx] = tgt;
      end else if (hit) begin
        m_ctr[uidx] = (m_ctr[uidx] > 0) ? m_ctr[uidx] - 1 : 0;
      end else if (tk) begin
        m_valid[uidx] = 1'b1;
        m_tag[uidx]   = upc >> 6;
        m_ctr[uidx]   = 2;
        m_tgt[uidx]   = tgt;
      end
      m_flush = (tk != pt);
      if (tk != pt) begin
        m_flush_pc = tk ? tgt : upc + 32'd4;
        if (m_cnt < 65535) m_cnt++;
      end
    end else begin
      m_flush = 1'b0;
    end
  endtask

  task automatic idle(input logic [31:0] lpc);
    step(lpc, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  localparam logic [31:0] PA = 32'h0040_0010;
  localparam logic [31:0] PB = 32'h0041_0010;
  localparam logic [31:0] PC = 32'h0042_0010;
  localparam logic [31:0] TA = 32'h0040_0100;

  initial begin
    logic [31:0] lpc, upc, tgt;
    bit          pt;
    model_reset();
    #12 rst_n = 1'b1;

    // reset state and first allocation through a mispredict
    idle(PA);
    step(PA, 1'b1, PA, 1'b1, 1'b1, TA, 1'b0);
    idle(PA);
    check_eq("tp_flush_1", flush, 32'd1);
    check_eq("tp_flush_pc_1", flush_pc, TA);
    check_eq("tp_cnt_1", mispredict_cnt, 32'd1);
    check_eq("tp_hit_a", pred_hit, 32'd1);
    check_eq("tp_target_a", pred_target, TA);

    // bne with eq=1 is not taken: 10 -> 01 -> 00, flushing to PA+4
    step(PA, 1'b1, PA, 1'b1, 1'b0, TA, 1'b1);
    step(PA, 1'b1, PA, 1'b1, 1'b0, TA, 1'b1);
    idle(PA);
    check_eq("tp_flush_pc_2", flush_pc, 32'h0040_0014);
    check_eq("tp_taken_00", pred_taken, 32'd0);
    for (int i = 0; i < 3; i++) step(PA, 1'b1, PA, 1'b0, 1'b1, TA, 1'b0);
    idle(PA);
    check_eq("tp_cnt_after_nt", mispredict_cnt, 32'd3);

    // saturate high, then one not-taken keeps the prediction taken
    for (int i = 0; i < 4; i++) step(PA, 1'b1, PA, 1'b1, 1'b1, TA, m_pred(PA));
    step(PA, 1'b1, PA, 1'b0, 1'b1, TA, m_pred(PA));
    idle(PA);
    check_eq("tp_still_taken", pred_taken, 32'd1);

    // aliasing: taken allocation evicts, not-taken miss does not
    step(PA, 1'b1, PB, 1'b1, 1'b1, 32'h0041_0200, 1'b0);
    idle(PA);
    check_eq("tp_alias_miss", pred_hit, 32'd0);
    step(PB, 1'b1, PC, 1'b0, 1'b1, 32'h0042_0300, 1'b0);
    idle(PB);
    check_eq("tp_alias_keep", pred_target, 32'h0041_0200);

    // same-cycle lookup and update of the same entry
    step(PB, 1'b1, PB, 1'b0, 1'b1, 32'd0, 1'b1);
    step(PB, 1'b1, PB, 1'b0, 1'b1, 32'd0, 1'b1);
    idle(PB);
    check_eq("tp_same_cycle_new", pred_taken, 32'd0);

    // asynchronous reset mid-stream with a flush pending
    step(PA, 1'b1, PA, 1'b1, 1'b1, TA, 1'b0);
    @(posedge clk);
    #2;
    check_eq("rst_pre_flush", flush, 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_flush", flush, 32'd0);
    check_eq("rst_cnt", mispredict_cnt, 32'd0);
    check_eq("rst_hit", pred_hit, 32'd0);
    upd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic over a few aliasing PCs
    for (int n = 0; n < 400; n++) begin
      lpc = 32'h0040_0000 + ($urandom_range(0, 2) << 16) + ($urandom_range(0, 5) << 2);
      upc = 32'h0040_0000 + ($urandom_range(0, 2) << 16) + ($urandom_range(0, 5) << 2);
      if ($urandom_range(0, 3) == 0) upc = lpc;
      tgt = $urandom & 32'hFFFF_FFFC;
      pt  = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : m_pred(upc);
      step(lpc, 1'($urandom_range(0, 4) != 0), upc, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), tgt, pt);
    end
    idle(32'hFFFF_FFFC);
    idle(32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
